alarm_challenge_ctrl: RTL and testbench
=======================================

Name: alarm_challenge_ctrl

Overview:
- Dismiss-challenge sequencer for the alarm clock.
- On an alarm trigger it runs the 2-bit random generator to build a SEQ_LEN symbol sequence, then replays it on the display.
- It checks the user's debounced button presses against the sequence and silences the buzzer only after a correct full entry.
- It sits between the alarm-time comparator, the random generator, the display mux and the button debouncers.

Parameters:
- SEQ_LEN, 4: symbols per challenge (legal range 2..8).
- SHOW_TICKS, 8: tick strobes each symbol is displayed.
- INPUT_TICKS, 40: tick strobes allowed between presses before timeout.
- MAX_TRIES, 3: failed attempts before a fresh sequence is generated.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-high.
- alarm_trig  in  1  one-cycle pulse: alarm time reached.
- tick  in  1  one-cycle slow-timebase strobe.
- rnd  in  2  random symbol from the generator's registered output.
- btn_valid  in  1  one-cycle pulse: debounced press.
- btn_code  in  2  button pressed; valid with btn_valid.
- lfsr_enable  out  1  generator advance enable.
- lfsr_stop  out  1  generator output-clear request.
- show_valid  out  1  display shows show_sym.
- show_sym  out  2  symbol being shown.
- show_idx  out  3  index of shown or expected symbol.
- buzzer  out  1  alarm sound on.
- dismissed  out  1  one-cycle pulse: challenge passed.
- fail_cnt  out  2  failed attempts on the current sequence (saturates at 3).
- state_o  out  3  current state encoding, for debug.

Behaviour:
- Reset values: all outputs 0, state IDLE, sequence register 0, idx 0, tick counter 0.
- States: IDLE=0, GEN=1, SHOW=2, INPUT=3, DONE=4.
- IDLE:
  - lfsr_stop=1, buzzer=0.
  - alarm_trig -> GEN next cycle, buzzer=1, fail_cnt=0, idx=0.
- GEN:
  - lfsr_enable=1 for exactly SEQ_LEN+1 cycles.
  - The generator output is registered, so rnd is not sampled on the first GEN cycle.
  - On GEN cycle k+1 (k=0..SEQ_LEN-1), rnd is stored into seq[k].
  - After the last store -> SHOW with idx=0, tick counter=0.
- SHOW:
  - show_valid=1, show_sym=seq[idx], show_idx=idx.
  - Count tick strobes; on the SHOW_TICKS-th tick, idx increments and the counter clears.
  - After seq[SEQ_LEN-1] completes -> INPUT with idx=0, counter=0.
  - btn_valid in SHOW is ignored.
- INPUT:
  - show_valid=0, show_idx=idx (expected position).
  - btn_valid with btn_code==seq[idx]: idx++, counter clears. If idx was SEQ_LEN-1 -> DONE.
  - Mismatch, or INPUT_TICKS ticks with no press, is a failure: fail_cnt++ (saturating), idx=0.
    - fail_cnt+1 < MAX_TRIES -> SHOW (replay same sequence).
    - Otherwise -> GEN (new sequence), fail_cnt=0.
- DONE: one cycle. dismissed=1, buzzer=0 from the next cycle, then -> IDLE.
- buzzer:
  - Registered; set on the accepted alarm_trig.
  - Cleared only on DONE exit or reset.
  - Stays 1 through all failures and regeneration.
- lfsr_enable is 0 outside GEN. lfsr_stop is 1 only in IDLE.
- Simultaneous events:
  - alarm_trig outside IDLE is ignored; no restart.
  - tick and btn_valid in the same INPUT cycle: the press wins and the timeout counter clears.
  - A press on the exact timeout tick is judged as a press.
- The tick counter is wide enough for max(SHOW_TICKS, INPUT_TICKS). idx width is 3; SEQ_LEN>8 is illegal.
- Reset mid-operation returns to IDLE immediately (asynchronous): buzzer=0, sequence discarded.

Decomposition:
- Shared package alarm_pkg holds:
  - the state encoding constants (IDLE..DONE, 3-bit);
  - the symbol width constant SYM_W=2;
  - a MAX_SEQ=8 constant.
- One natural sub-module: tick_timer. It is a loadable tick-strobe counter with clear input and terminal-count output, reused by SHOW and INPUT.
- Sequence storage stays in the top level as a SEQ_LEN x 2 register array.

Test Plan:
- Pass path: reset, then alarm_trig.
  - GEN holds lfsr_enable for 5 cycles with SEQ_LEN=4.
  - rnd driven 2,1,3,0 on GEN cycles 2..5 gives show_sym 2,1,3,0, each for 8 ticks.
  - Presses 2,1,3,0 -> dismissed pulses 1 cycle, buzzer 0, state_o=0.
- Mismatch replay: sequence 2,1,3,0, presses 2,3.
  - Result: fail_cnt=1, state SHOW, replayed sequence identical to 2,1,3,0, buzzer still 1.
- Regeneration: three consecutive wrong first presses.
  - Result: after the third, state GEN, fail_cnt=0, lfsr_enable high 5 cycles, new rnd values stored.
- Timeout: in INPUT, no press for 40 ticks.
  - Result: fail_cnt increments to 1 and SHOW re-enters.
  - Also, a press coincident with the 40th tick is compared, not timed out.
- Ignored events: alarm_trig pulsed during SHOW and INPUT, and btn_valid during SHOW.
  - Result: no state, idx or fail_cnt change.
- Async reset: assert rst_n mid-INPUT between clock edges.
  - Result: buzzer, show_valid and lfsr_enable drop immediately, state_o=0.
  - A subsequent alarm_trig starts a fresh GEN.

Source files
------------

// File: rtl/alarm_challenge_ctrl_pkg.sv
// Shared definitions for the alarm dismiss-challenge sequencer: state encoding,
// symbol/index widths and a small elaboration helper.
package alarm_pkg;
  localparam int SYM_W   = 2;
  localparam int MAX_SEQ = 8;
  localparam int IDX_W   = $clog2(MAX_SEQ);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GEN   = 3'd1,
    SHOW  = 3'd2,
    INPUT = 3'd3,
    DONE  = 3'd4
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/alarm_challenge_ctrl_if.sv
// Signal bundle between the challenge sequencer and its neighbours
// (alarm comparator, random generator, display mux, button debouncers).
interface alarm_challenge_ctrl_if;
  logic                        alarm_trig;
  logic                        tick;
  logic [alarm_pkg::SYM_W-1:0] rnd;
  logic                        btn_valid;
  logic [alarm_pkg::SYM_W-1:0] btn_code;
  logic                        lfsr_enable;
  logic                        lfsr_stop;
  logic                        show_valid;
  logic [alarm_pkg::SYM_W-1:0] show_sym;
  logic [alarm_pkg::IDX_W-1:0] show_idx;
  logic                        buzzer;
  logic                        dismissed;
  logic [1:0]                  fail_cnt;
  logic [2:0]                  state_o;

  modport master (
    output alarm_trig, tick, rnd, btn_valid, btn_code,
    input  lfsr_enable, lfsr_stop, show_valid, show_sym, show_idx,
           buzzer, dismissed, fail_cnt, state_o
  );

  modport slave (
    input  alarm_trig, tick, rnd, btn_valid, btn_code,
    output lfsr_enable, lfsr_stop, show_valid, show_sym, show_idx,
           buzzer, dismissed, fail_cnt, state_o
  );
endinterface

// File: rtl/alarm_challenge_ctrl_tick_timer.sv
// Tick-strobe counter: counts strobes up to a runtime limit, flags the
// terminal strobe and wraps to zero; clear has priority over counting.
module tick_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             tick,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  assign tc = tick && !clr && (cnt_r == (limit - ONE));

  // Strobe counter, restarts on clear or at terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr || tc) begin
      cnt_r <= '0;
    end else if (tick) begin
      cnt_r <= cnt_r + ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end
endmodule

// File: rtl/alarm_challenge_ctrl.sv
// Alarm dismiss-challenge sequencer: generates a random symbol sequence,
// replays it on the display and silences the buzzer after a correct entry.
module alarm_challenge_ctrl import alarm_pkg::*; #(
  parameter int SEQ_LEN     = 4,
  parameter int SHOW_TICKS  = 8,
  parameter int INPUT_TICKS = 40,
  parameter int MAX_TRIES   = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  alarm_challenge_ctrl_if.slave bus
);
  localparam int               CNT_W    = $clog2(max_int(SHOW_TICKS, INPUT_TICKS) + 1);
  localparam int               SEL_W    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);

  state_e             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic [1:0]         fail_r;
  logic               primed_r;
  logic [SYM_W-1:0]   seq_r [SEQ_LEN];
  logic [SYM_W-1:0]   show_sym_r;
  logic               show_valid_r;
  logic               lfsr_en_r;
  logic               lfsr_stop_r;
  logic               buzzer_r;
  logic               dismissed_r;

  logic [IDX_W-1:0]   nxt_idx_s;
  logic [SEL_W-1:0]   sel_cur_s;
  logic [SEL_W-1:0]   sel_nxt_s;
  logic               tmr_clr_s;
  logic               tmr_tc_s;
  logic [CNT_W-1:0]   tmr_limit_s;
  logic               match_s;
  logic               fail_s;
  logic               retry_s;

  assign nxt_idx_s   = idx_r + 3'd1;
  assign sel_cur_s   = idx_r[SEL_W-1:0];
  assign sel_nxt_s   = nxt_idx_s[SEL_W-1:0];
  // A press in INPUT restarts the timeout window, even on a coincident tick.
  assign tmr_clr_s   = !((state_r == SHOW) || (state_r == INPUT)) ||
                       ((state_r == INPUT) && bus.btn_valid);
  assign tmr_limit_s = (state_r == SHOW) ? CNT_W'(SHOW_TICKS) : CNT_W'(INPUT_TICKS);
  assign match_s     = (bus.btn_code == seq_r[sel_cur_s]);
  assign fail_s      = bus.btn_valid ? !match_s : tmr_tc_s;
  assign retry_s     = (int'(fail_r) + 1) < MAX_TRIES;

  tick_timer #(.CNT_W(CNT_W)) u_tick_timer (
    .clk   (clk),
    .rst   (rst_n),
    .clr   (tmr_clr_s),
    .tick  (bus.tick),
    .limit (tmr_limit_s),
    .tc    (tmr_tc_s)
  );

  // Challenge FSM with registered outputs
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r      <= IDLE;
      idx_r        <= '0;
      fail_r       <= 2'd0;
      primed_r     <= 1'b0;
      show_sym_r   <= '0;
      show_valid_r <= 1'b0;
      lfsr_en_r    <= 1'b0;
      lfsr_stop_r  <= 1'b0;
      buzzer_r     <= 1'b0;
      dismissed_r  <= 1'b0;
      for (int i = 0; i < SEQ_LEN; i++) seq_r[i] <= '0;
    end else begin
      dismissed_r <= 1'b0;
      case (state_r)
        IDLE: begin
          lfsr_stop_r <= 1'b1;
          if (bus.alarm_trig) begin
            state_r     <= GEN;
            buzzer_r    <= 1'b1;
            fail_r      <= 2'd0;
            idx_r       <= '0;
            primed_r    <= 1'b0;
            lfsr_en_r   <= 1'b1;
            lfsr_stop_r <= 1'b0;
          end
        end
        GEN: begin
          // First GEN cycle only advances the generator; its output lags by one.
          primed_r <= 1'b1;
          if (primed_r) begin
            seq_r[sel_cur_s] <= bus.rnd;
            if (idx_r == LAST_IDX) begin
              state_r      <= SHOW;
              idx_r        <= '0;
              lfsr_en_r    <= 1'b0;
              show_valid_r <= 1'b1;
              show_sym_r   <= seq_r[0];
            end else begin
              idx_r <= nxt_idx_s;
            end
          end
        end
        SHOW: begin
          if (tmr_tc_s) begin
            if (idx_r == LAST_IDX) begin
              state_r      <= INPUT;
              idx_r        <= '0;
              show_valid_r <= 1'b0;
              show_sym_r   <= '0;
            end else begin
              idx_r      <= nxt_idx_s;
              show_sym_r <= seq_r[sel_nxt_s];
            end
          end
        end
        INPUT: begin
          if (fail_s) begin
            idx_r <= '0;
            if (retry_s) begin
              state_r      <= SHOW;
              fail_r       <= (fail_r == 2'd3) ? 2'd3 : fail_r + 2'd1;
              show_valid_r <= 1'b1;
              show_sym_r   <= seq_r[0];
            end else begin
              state_r   <= GEN;
              fail_r    <= 2'd0;
              primed_r  <= 1'b0;
              lfsr_en_r <= 1'b1;
            end
          end else if (bus.btn_valid) begin
            if (idx_r == LAST_IDX) begin
              state_r     <= DONE;
              idx_r       <= '0;
              dismissed_r <= 1'b1;
            end else begin
              idx_r <= nxt_idx_s;
            end
          end
        end
        DONE: begin
          state_r     <= IDLE;
          buzzer_r    <= 1'b0;
          lfsr_stop_r <= 1'b1;
        end
        default: begin
          state_r      <= IDLE;
          idx_r        <= '0;
          buzzer_r     <= 1'b0;
          lfsr_en_r    <= 1'b0;
          show_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.lfsr_enable = lfsr_en_r;
  assign bus.lfsr_stop   = lfsr_stop_r;
  assign bus.show_valid  = show_valid_r;
  assign bus.show_sym    = show_sym_r;
  assign bus.show_idx    = idx_r;
  assign bus.buzzer      = buzzer_r;
  assign bus.dismissed   = dismissed_r;
  assign bus.fail_cnt    = fail_r;
  assign bus.state_o     = state_r;
endmodule

// File: tb/tb_alarm_challenge_ctrl.sv
// Self-checking bench for alarm_challenge_ctrl: table-driven challenge vectors
// plus directed regeneration, timeout, ignored-event and async-reset sequences.
module tb_alarm_challenge_ctrl;
  import alarm_pkg::*;

  typedef struct {
    logic [7:0] seq;
    logic [7:0] press;
    int         n_press;
    logic [2:0] exp_state;
    logic [1:0] exp_fail;
    logic       exp_dis;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [1:0] show_q [$];
  logic [1:0] m_seq [4];
  vec_t tbl [4];

  alarm_challenge_ctrl_if bus ();

  alarm_challenge_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] pk(input logic [1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_pulse();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    step();
  endtask

  task automatic press(input logic [1:0] code);
    bus.btn_valid = 1'b1;
    bus.btn_code  = code;
    step();
    bus.btn_valid = 1'b0;
  endtask

  task automatic push_seq();
    for (int k = 0; k < 4; k++) show_q.push_back(m_seq[k]);
  endtask

  task automatic start();
    bus.alarm_trig = 1'b1;
    step();
    bus.alarm_trig = 1'b0;
    chk("trig_state", bus.state_o, 32'd1);
    chk("trig_buzzer", bus.buzzer, 32'd1);
    chk("trig_fail", bus.fail_cnt, 32'd0);
    chk("trig_lfsr_stop", bus.lfsr_stop, 32'd0);
  endtask

  // Drives rnd through GEN; expected display symbols go to the scoreboard.
  task automatic do_gen(input logic [7:0] sv);
    int en_cnt;
    int c;
    en_cnt = 0;
    c = 0;
    chk("gen_entry", bus.state_o, 32'd1);
    for (int k = 0; k < 4; k++) begin
      m_seq[k] = sv[2*k +: 2];
      show_q.push_back(sv[2*k +: 2]);
    end
    while (bus.state_o == 3'd1 && c < 12) begin
      if (bus.lfsr_enable) en_cnt++;
      if (c == 0) bus.rnd = m_seq[0] ^ 2'b11;
      else if (c <= 4) bus.rnd = m_seq[c-1];
      else bus.rnd = 2'b00;
      step();
      c++;
    end
    chk("gen_len", en_cnt, 32'd5);
    chk("gen_lfsr_off", bus.lfsr_enable, 32'd0);
    chk("gen_to_show", bus.state_o, 32'd2);
  endtask

  task automatic do_show();
    logic [1:0] e;
    for (int i = 0; i < 4; i++) begin
      if (show_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL show_q: got empty expected symbol");
        e = 2'd0;
      end else begin
        e = show_q.pop_front();
      end
      chk("show_valid", bus.show_valid, 32'd1);
      chk("show_idx", bus.show_idx, i);
      chk("show_sym", bus.show_sym, e);
      repeat (8) tick_pulse();
    end
    chk("show_to_input", bus.state_o, 32'd3);
    chk("input_show_valid", bus.show_valid, 32'd0);
    chk("input_idx", bus.show_idx, 32'd0);
  endtask

  task automatic do_reset();
    #3;
    rst_n = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    step();
    show_q.delete();
  endtask

  initial begin
    bus.alarm_trig = 1'b0;
    bus.tick       = 1'b0;
    bus.rnd        = 2'd0;
    bus.btn_valid  = 1'b0;
    bus.btn_code   = 2'd0;

    tbl[0] = '{pk(2'd2, 2'd1, 2'd3, 2'd0), pk(2'd2, 2'd1, 2'd3, 2'd0), 4, 3'd4, 2'd0, 1'b1};
    tbl[1] = '{pk(2'd2, 2'd1, 2'd3, 2'd0), pk(2'd2, 2'd3, 2'd0, 2'd0), 2, 3'd2, 2'd1, 1'b0};
    tbl[2] = '{pk(2'd3, 2'd3, 2'd0, 2'd1), pk(2'd3, 2'd3, 2'd0, 2'd1), 4, 3'd4, 2'd0, 1'b1};
    tbl[3] = '{pk(2'd0, 2'd1, 2'd2, 2'd3), pk(2'd1, 2'd0, 2'd0, 2'd0), 1, 3'd2, 2'd1, 1'b0};

    repeat (3) step();
    chk("rst_state", bus.state_o, 32'd0);
    chk("rst_buzzer", bus.buzzer, 32'd0);
    chk("rst_lfsr_stop", bus.lfsr_stop, 32'd0);
    chk("rst_lfsr_en", bus.lfsr_enable, 32'd0);
    chk("rst_show_valid", bus.show_valid, 32'd0);
    chk("rst_show_sym", bus.show_sym, 32'd0);
    chk("rst_show_idx", bus.show_idx, 32'd0);
    chk("rst_dismissed", bus.dismissed, 32'd0);
    chk("rst_fail", bus.fail_cnt, 32'd0);
    rst_n = 1'b0;
    step();
    chk("idle_lfsr_stop", bus.lfsr_stop, 32'd1);
    chk("idle_state", bus.state_o, 32'd0);

    for (int v = 0; v < 4; v++) begin
      start();
      do_gen(tbl[v].seq);
      do_show();
      for (int p = 0; p < tbl[v].n_press; p++) press(tbl[v].press[2*p +: 2]);
      chk("vec_state", bus.state_o, tbl[v].exp_state);
      chk("vec_fail", bus.fail_cnt, tbl[v].exp_fail);
      chk("vec_dismissed", bus.dismissed, tbl[v].exp_dis);
      chk("vec_buzzer", bus.buzzer, 32'd1);
      if (tbl[v].exp_dis) begin
        step();
        chk("done_dismissed", bus.dismissed, 32'd0);
        chk("done_buzzer", bus.buzzer, 32'd0);
        chk("done_state", bus.state_o, 32'd0);
        chk("done_lfsr_stop", bus.lfsr_stop, 32'd1);
      end else begin
        push_seq();
        do_show();
        chk("replay_buzzer", bus.buzzer, 32'd1);
        chk("replay_fail", bus.fail_cnt, tbl[v].exp_fail);
        do_reset();
      end
    end

    // Regeneration after three wrong first presses, with ignored events.
    start();
    do_gen(pk(2'd2, 2'd1, 2'd3, 2'd0));
    bus.alarm_trig = 1'b1;
    step();
    bus.alarm_trig = 1'b0;
    chk("ign_trig_show_state", bus.state_o, 32'd2);
    chk("ign_trig_show_idx", bus.show_idx, 32'd0);
    press(2'd1);
    chk("ign_btn_show_state", bus.state_o, 32'd2);
    chk("ign_btn_show_idx", bus.show_idx, 32'd0);
    chk("ign_btn_show_fail", bus.fail_cnt, 32'd0);
    do_show();
    bus.alarm_trig = 1'b1;
    step();
    bus.alarm_trig = 1'b0;
    chk("ign_trig_in_state", bus.state_o, 32'd3);
    chk("ign_trig_in_idx", bus.show_idx, 32'd0);
    chk("ign_trig_in_fail", bus.fail_cnt, 32'd0);
    press(2'd1);
    chk("regen_f1_fail", bus.fail_cnt, 32'd1);
    chk("regen_f1_state", bus.state_o, 32'd2);
    push_seq();
    do_show();
    press(2'd0);
    chk("regen_f2_fail", bus.fail_cnt, 32'd2);
    chk("regen_f2_state", bus.state_o, 32'd2);
    push_seq();
    do_show();
    press(2'd3);
    chk("regen_fail", bus.fail_cnt, 32'd0);
    chk("regen_buzzer", bus.buzzer, 32'd1);
    do_gen(pk(2'd1, 2'd0, 2'd2, 2'd3));
    do_show();
    for (int k = 0; k < 4; k++) press(m_seq[k]);
    chk("regen_dismissed", bus.dismissed, 32'd1);
    step();
    chk("regen_buzzer_off", bus.buzzer, 32'd0);

    // Timeout, then a press coincident with the terminal tick.
    start();
    do_gen(pk(2'd3, 2'd0, 2'd1, 2'd2));
    do_show();
    repeat (39) tick_pulse();
    chk("to39_state", bus.state_o, 32'd3);
    chk("to39_fail", bus.fail_cnt, 32'd0);
    tick_pulse();
    chk("to40_state", bus.state_o, 32'd2);
    chk("to40_fail", bus.fail_cnt, 32'd1);
    chk("to40_buzzer", bus.buzzer, 32'd1);
    push_seq();
    do_show();
    repeat (39) tick_pulse();
    bus.tick      = 1'b1;
    bus.btn_valid = 1'b1;
    bus.btn_code  = m_seq[0];
    step();
    bus.tick      = 1'b0;
    bus.btn_valid = 1'b0;
    chk("coinc_state", bus.state_o, 32'd3);
    chk("coinc_idx", bus.show_idx, 32'd1);
    chk("coinc_fail", bus.fail_cnt, 32'd1);
    repeat (39) tick_pulse();
    chk("coinc_clr_state", bus.state_o, 32'd3);
    chk("coinc_clr_idx", bus.show_idx, 32'd1);
    for (int k = 1; k < 4; k++) press(m_seq[k]);
    chk("to_dismissed", bus.dismissed, 32'd1);
    step();

    // Asynchronous reset in the middle of INPUT.
    start();
    do_gen(pk(2'd1, 2'd1, 2'd2, 2'd2));
    do_show();
    press(m_seq[0]);
    chk("ar_pre_idx", bus.show_idx, 32'd1);
    #3;
    rst_n = 1'b1;
    #1;
    chk("ar_buzzer", bus.buzzer, 32'd0);
    chk("ar_show_valid", bus.show_valid, 32'd0);
    chk("ar_lfsr_en", bus.lfsr_enable, 32'd0);
    chk("ar_state", bus.state_o, 32'd0);
    chk("ar_idx", bus.show_idx, 32'd0);
    step();
    rst_n = 1'b0;
    step();
    show_q.delete();
    start();
    do_gen(pk(2'd0, 2'd3, 2'd3, 2'd1));
    do_show();
    for (int k = 0; k < 4; k++) press(m_seq[k]);
    chk("ar_dismissed", bus.dismissed, 32'd1);
    step();
    chk("ar_end_state", bus.state_o, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
